// File: rtl/core_rvfi_monitor_pkg.sv
// Shared definitions for the RVFI retirement monitor: FSM states and
// error-flag bit positions within err_flags.
package core_rvfi_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } mon_state_e;

    localparam int unsigned ERR_ORDER = 0;
    localparam int unsigned ERR_PC    = 1;
    localparam int unsigned ERR_RS1   = 2;
    localparam int unsigned ERR_RS2   = 3;
    localparam int unsigned ERR_X0    = 4;
    localparam int unsigned ERR_HALT  = 5;
    localparam int unsigned NUM_ERR   = 6;

endpackage

// File: rtl/core_rvfi_monitor_shadow_rf.sv
// Shadow integer register file: two async read ports, one write port and a
// known-bit vector. Each read port can also learn its observed value.
module core_rvfi_shadow_rf #(
    parameter int unsigned XLEN = 64
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic [4:0]      rs1_addr_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic            rs1_known_o,
    input  logic            rs1_learn_i,
    input  logic [XLEN-1:0] rs1_learn_data_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [XLEN-1:0] rs2_data_o,
    output logic            rs2_known_o,
    input  logic            rs2_learn_i,
    input  logic [XLEN-1:0] rs2_learn_data_i,
    input  logic            wr_en_i,
    input  logic [4:0]      wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i
);

    logic [XLEN-1:0] data_q [32];
    logic [31:0]     known_q;

    // Entry 0 is never written; x0 is hard-wired known-zero on the read side.
    always_comb begin
        rs1_data_o  = (rs1_addr_i == 5'd0) ? '0 : data_q[rs1_addr_i];
        rs2_data_o  = (rs2_addr_i == 5'd0) ? '0 : data_q[rs2_addr_i];
        rs1_known_o = known_q[rs1_addr_i];
        rs2_known_o = known_q[rs2_addr_i];
    end

    // Later assignments win, so a retiring write overrides same-index learning.
    always_ff @(posedge g_clk) begin
        if (rs1_learn_i && rs1_addr_i != 5'd0) data_q[rs1_addr_i] <= rs1_learn_data_i;
        if (rs2_learn_i && rs2_addr_i != 5'd0) data_q[rs2_addr_i] <= rs2_learn_data_i;
        if (wr_en_i && wr_addr_i != 5'd0)      data_q[wr_addr_i]  <= wr_data_i;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            known_q <= 32'h0000_0001;
        end else begin
            if (rs1_learn_i) known_q[rs1_addr_i] <= 1'b1;
            if (rs2_learn_i) known_q[rs2_addr_i] <= 1'b1;
            if (wr_en_i)     known_q[wr_addr_i]  <= 1'b1;
        end
    end

endmodule

// File: rtl/core_rvfi_monitor.sv
// RVFI retirement monitor: checks order/PC continuity, x0 writes and register
// read consistency against a shadow register file; reports sticky error flags.
module core_rvfi_monitor
    import core_rvfi_monitor_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            rvfi_valid,
    input  logic [63:0]     rvfi_order,
    input  logic [ILEN-1:0] rvfi_insn,
    input  logic            rvfi_trap,
    input  logic            rvfi_intr,
    input  logic            rvfi_halt,
    input  logic [4:0]      rvfi_rs1_addr,
    input  logic [4:0]      rvfi_rs2_addr,
    input  logic [4:0]      rvfi_rd_addr,
    input  logic [XLEN-1:0] rvfi_rs1_rdata,
    input  logic [XLEN-1:0] rvfi_rs2_rdata,
    input  logic [XLEN-1:0] rvfi_rd_wdata,
    input  logic [XLEN-1:0] rvfi_pc_rdata,
    input  logic [XLEN-1:0] rvfi_pc_wdata,
    output logic            err_valid,
    output logic [5:0]      err_flags,
    output logic [63:0]     retired,
    output logic            halted
);

    mon_state_e          state_q, state_d;
    logic [63:0]         exp_order_q, exp_order_d;
    logic [XLEN-1:0]     exp_pc_q, exp_pc_d;
    logic [63:0]         retired_q, retired_d;
    logic [NUM_ERR-1:0]  flags_q, flags_d;
    logic                err_valid_q, err_valid_d;
    logic [NUM_ERR-1:0]  new_err;

    logic [XLEN-1:0]     rs1_data, rs2_data;
    logic                rs1_known, rs2_known;
    logic                rs1_learn, rs2_learn, wr_en;
    logic                unused_insn;

    assign unused_insn = ^rvfi_insn;

    core_rvfi_shadow_rf #(.XLEN(XLEN)) u_shadow (
        .g_clk            (g_clk),
        .g_resetn         (g_resetn),
        .rs1_addr_i       (rvfi_rs1_addr),
        .rs1_data_o       (rs1_data),
        .rs1_known_o      (rs1_known),
        .rs1_learn_i      (rs1_learn),
        .rs1_learn_data_i (rvfi_rs1_rdata),
        .rs2_addr_i       (rvfi_rs2_addr),
        .rs2_data_o       (rs2_data),
        .rs2_known_o      (rs2_known),
        .rs2_learn_i      (rs2_learn),
        .rs2_learn_data_i (rvfi_rs2_rdata),
        .wr_en_i          (wr_en),
        .wr_addr_i        (rvfi_rd_addr),
        .wr_data_i        (rvfi_rd_wdata)
    );

    always_comb begin
        state_d     = state_q;
        exp_order_d = exp_order_q;
        exp_pc_d    = exp_pc_q;
        retired_d   = retired_q;
        new_err     = '0;
        rs1_learn   = 1'b0;
        rs2_learn   = 1'b0;
        wr_en       = 1'b0;

        if (rvfi_valid) begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    new_err[ERR_RS1] = rs1_known && (rs1_data != rvfi_rs1_rdata);
                    new_err[ERR_RS2] = rs2_known && (rs2_data != rvfi_rs2_rdata);
                    new_err[ERR_X0]  = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
                    rs1_learn        = !rs1_known;
                    rs2_learn        = !rs2_known;
                    wr_en            = !rvfi_trap && (rvfi_rd_addr != 5'd0);
                    // The first packet after reset only seeds the order/PC expectations.
                    if (state_q == ST_RUN) begin
                        new_err[ERR_ORDER] = (rvfi_order != exp_order_q);
                        new_err[ERR_PC]    = !rvfi_intr && (rvfi_pc_rdata != exp_pc_q);
                        retired_d          = retired_q + 64'd1;
                    end
                    exp_order_d = rvfi_order + 64'd1;
                    exp_pc_d    = rvfi_pc_wdata;
                    state_d     = rvfi_halt ? ST_HALTED : ST_RUN;
                end
                ST_HALTED: new_err[ERR_HALT] = 1'b1;
                default:   state_d = ST_IDLE;
            endcase
        end

        flags_d     = flags_q | new_err;
        err_valid_d = |new_err;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q     <= ST_IDLE;
            exp_order_q <= '0;
            exp_pc_q    <= '0;
            retired_q   <= '0;
            flags_q     <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_order_q <= exp_order_d;
            exp_pc_q    <= exp_pc_d;
            retired_q   <= retired_d;
            flags_q     <= flags_d;
            err_valid_q <= err_valid_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_flags = flags_q;
    assign retired   = retired_q;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_core_rvfi_monitor.sv
// Self-checking bench for core_rvfi_monitor: directed scenarios plus random
// packet streams compared against a behavioural retirement model.
module tb_core_rvfi_monitor;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_insn = '0;
    logic        rvfi_trap = 1'b0, rvfi_intr = 1'b0, rvfi_halt = 1'b0;
    logic [4:0]  rvfi_rs1_addr = '0, rvfi_rs2_addr = '0, rvfi_rd_addr = '0;
    logic [63:0] rvfi_rs1_rdata = '0, rvfi_rs2_rdata = '0, rvfi_rd_wdata = '0;
    logic [63:0] rvfi_pc_rdata = '0, rvfi_pc_wdata = '0;
    logic        err_valid;
    logic [5:0]  err_flags;
    logic [63:0] retired;
    logic        halted;

    core_rvfi_monitor #(.XLEN(64), .ILEN(32)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .rvfi_valid(rvfi_valid),
        .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
        .rvfi_intr(rvfi_intr), .rvfi_halt(rvfi_halt),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rs1_rdata(rvfi_rs1_rdata),
        .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .err_valid(err_valid), .err_flags(err_flags), .retired(retired),
        .halted(halted)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        logic        v;
        logic [63:0] order, pcr, pcw, r1d, r2d, rdw;
        logic [4:0]  r1a, r2a, rda;
        logic        trp, itr, hlt;
    } pkt_t;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model: mode 0 = waiting for first packet, 1 = running, 2 = halted.
    int          m_mode;
    bit          m_known [32];
    logic [63:0] m_val   [32];
    logic [63:0] m_next_order, m_next_pc, m_ret;
    logic [5:0]  m_flags;
    logic        m_pulse;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reg_known(input logic [4:0] a);
        return (a == 5'd0) || m_known[a];
    endfunction

    function automatic logic [63:0] reg_val(input logic [4:0] a);
        return (a == 5'd0) ? 64'd0 : m_val[a];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_next_order = '0; m_next_pc = '0; m_ret = '0;
        m_flags = '0; m_pulse = 1'b0;
        for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
    endtask

    task automatic model_pkt(input pkt_t p);
        logic [5:0] e;
        e = '0;
        if (p.v) begin
            if (m_mode == 2) begin
                e[5] = 1'b1;
            end else begin
                if (reg_known(p.r1a) && reg_val(p.r1a) != p.r1d) e[2] = 1'b1;
                if (reg_known(p.r2a) && reg_val(p.r2a) != p.r2d) e[3] = 1'b1;
                if (p.rda == 5'd0 && p.rdw != 64'd0) e[4] = 1'b1;
                if (m_mode == 1) begin
                    if (p.order != m_next_order) e[0] = 1'b1;
                    if (!p.itr && p.pcr != m_next_pc) e[1] = 1'b1;
                    m_ret = m_ret + 64'd1;
                end
                if (!reg_known(p.r1a)) begin m_known[p.r1a] = 1'b1; m_val[p.r1a] = p.r1d; end
                if (!reg_known(p.r2a)) begin m_known[p.r2a] = 1'b1; m_val[p.r2a] = p.r2d; end
                if (!p.trp && p.rda != 5'd0) begin m_known[p.rda] = 1'b1; m_val[p.rda] = p.rdw; end
                m_next_order = p.order + 64'd1;
                m_next_pc    = p.pcw;
                m_mode       = p.hlt ? 2 : 1;
            end
        end
        m_flags = m_flags | e;
        m_pulse = (e != 6'd0);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic step(input pkt_t p, input string tag);
        rvfi_valid = p.v; rvfi_order = p.order; rvfi_insn = $urandom;
        rvfi_trap = p.trp; rvfi_intr = p.itr; rvfi_halt = p.hlt;
        rvfi_rs1_addr = p.r1a; rvfi_rs2_addr = p.r2a; rvfi_rd_addr = p.rda;
        rvfi_rs1_rdata = p.r1d; rvfi_rs2_rdata = p.r2d; rvfi_rd_wdata = p.rdw;
        rvfi_pc_rdata = p.pcr; rvfi_pc_wdata = p.pcw;
        model_pkt(p);
        @(negedge g_clk);
        check({tag, ".err_valid"}, {63'd0, err_valid}, {63'd0, m_pulse});
        check({tag, ".err_flags"}, {58'd0, err_flags}, {58'd0, m_flags});
        check({tag, ".retired"},   retired, m_ret);
        check({tag, ".halted"},    {63'd0, halted}, {63'd0, m_mode == 2});
    endtask

    function automatic pkt_t mk(input logic [63:0] order, input logic [63:0] pc);
        pkt_t p;
        p.v = 1'b1; p.order = order; p.pcr = pc; p.pcw = pc + 64'd4;
        p.r1a = 5'd0; p.r2a = 5'd0; p.rda = 5'd0;
        p.r1d = '0; p.r2d = '0; p.rdw = '0;
        p.trp = 1'b0; p.itr = 1'b0; p.hlt = 1'b0;
        return p;
    endfunction

    function automatic pkt_t idle_pkt();
        pkt_t p;
        p = mk(64'd0, 64'd0);
        p.v = 1'b0;
        return p;
    endfunction

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string tag);
        rvfi_valid = 1'b0;
        #2 g_resetn = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_err_valid"}, {63'd0, err_valid}, 64'd0);
        check({tag, ".rst_err_flags"}, {58'd0, err_flags}, 64'd0);
        check({tag, ".rst_retired"},   retired, 64'd0);
        check({tag, ".rst_halted"},    {63'd0, halted}, 64'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
    endtask

    task automatic rand_pkt(output pkt_t p);
        p = mk(m_next_order, m_next_pc);
        p.v = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 9) == 0) p.order = m_next_order + 64'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) p.itr = 1'b1;
        if (p.itr || $urandom_range(0, 12) == 0) p.pcr = {$urandom, $urandom} & ~64'd3;
        p.pcw = ($urandom_range(0, 7) == 0) ? ({$urandom, $urandom} & ~64'd3) : p.pcr + 64'd4;
        p.r1a = 5'($urandom_range(0, 7));
        p.r2a = 5'((p.r1a + 5'($urandom_range(1, 6))) % 8);
        p.rda = 5'($urandom_range(0, 7));
        p.r1d = reg_known(p.r1a) ? reg_val(p.r1a) : {$urandom, $urandom};
        p.r2d = reg_known(p.r2a) ? reg_val(p.r2a) : {$urandom, $urandom};
        if ($urandom_range(0, 11) == 0) p.r1d = p.r1d ^ 64'd1;
        if ($urandom_range(0, 11) == 0) p.r2d = p.r2d ^ 64'h100;
        p.rdw = (p.rda == 5'd0 && $urandom_range(0, 7) != 0) ? 64'd0 : {$urandom, $urandom};
        p.trp = ($urandom_range(0, 9) == 0);
        p.hlt = ($urandom_range(0, 69) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pkt_t p;
        model_reset();
        @(negedge g_clk);
        do_reset("init");

        // Continuous orders and PCs: no errors, second and third packets retire.
        step(mk(64'd5, 64'h1000), "cont0");
        step(mk(64'd6, 64'h1004), "cont1");
        step(mk(64'd7, 64'h1008), "cont2");
        check("cont.retired_const", retired, 64'd2);
        step(idle_pkt(), "cont_idle");

        // One order gap gives exactly one error.
        do_reset("gap");
        step(mk(64'd5, 64'h1000), "gap0");
        step(mk(64'd6, 64'h1004), "gap1");
        step(mk(64'd8, 64'h1008), "gap2");
        check("gap.flags_const", {58'd0, err_flags}, 64'h01);
        step(mk(64'd9, 64'h100c), "gap3");
        check("gap.no_pulse", {63'd0, err_valid}, 64'd0);

        // Shadow write, mismatching read back-to-back, trapped write ignored.
        do_reset("rs");
        p = mk(64'd1, 64'h200); p.rda = 5'd3; p.rdw = 64'hAB; step(p, "rs_wr");
        p = mk(64'd2, 64'h204); p.r1a = 5'd3; p.r1d = 64'hAC; step(p, "rs_bad");
        check("rs.flags_const", {58'd0, err_flags}, 64'h04);
        p = mk(64'd3, 64'h208); p.rda = 5'd3; p.rdw = 64'h55; p.trp = 1'b1; step(p, "rs_trap");
        p = mk(64'd4, 64'h20c); p.r2a = 5'd3; p.r2d = 64'hAB; step(p, "rs_after_trap");
        p = mk(64'd5, 64'h210); p.r1a = 5'd3; p.rda = 5'd3; p.r1d = 64'hAB; p.rdw = 64'h77; step(p, "rs_same");
        p = mk(64'd6, 64'h214); p.r2a = 5'd3; p.r2d = 64'h78; step(p, "rs2_bad");
        check("rs2.flags_const", {58'd0, err_flags}, 64'h0C);

        // x0 write, PC mismatch excused by interrupt, then a real PC error.
        do_reset("x0");
        p = mk(64'd1, 64'h300); p.rdw = 64'h1; step(p, "x0_wr");
        check("x0.flags_const", {58'd0, err_flags}, 64'h10);
        p = mk(64'd2, 64'h8000); p.itr = 1'b1; step(p, "pc_intr");
        check("pc_intr.flags_const", {58'd0, err_flags}, 64'h10);
        p = mk(64'd3, 64'h9000); step(p, "pc_bad");
        check("pc_bad.flags_const", {58'd0, err_flags}, 64'h12);

        // Halt, then a further packet: HALT flag, counter frozen.
        do_reset("halt");
        step(mk(64'd1, 64'h400), "halt0");
        p = mk(64'd2, 64'h404); p.hlt = 1'b1; step(p, "halt1");
        step(idle_pkt(), "halt_idle");
        step(mk(64'd77, 64'h0), "halt_post");
        check("halt.flags_const", {58'd0, err_flags}, 64'h20);
        check("halt.retired_const", retired, 64'd1);

        // Reset after errors discards history.
        do_reset("mid");
        step(mk(64'h1234_5678, 64'hABC0), "mid0");
        check("mid.flags_const", {58'd0, err_flags}, 64'h00);

        for (int seg = 0; seg < 4; seg++) begin
            do_reset("rnd");
            for (int i = 0; i < 80; i++) begin
                rand_pkt(p);
                step(p, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/core_rvfi_monitor.md
CORE_RVFI_MONITOR -- requirements
Module: core_rvfi_monitor

Interface
REQ-001 Parameter XLEN, default 64, integer register width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 g_clk  input  1  single clock; all state on rising edge.
REQ-004 g_resetn  input  1  asynchronous active-low reset.
REQ-005 rvfi_valid  input  1  one retired instruction this cycle.
REQ-006 rvfi_order  input  64  retirement index.
REQ-007 rvfi_insn  input  ILEN  retired instruction word.
REQ-008 rvfi_trap, rvfi_intr, rvfi_halt  input  1 each  trap taken, first instruction of handler, core halted.
REQ-009 rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  input  5 each  register indices.
REQ-010 rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  input  XLEN each  register data.
REQ-011 rvfi_pc_rdata, rvfi_pc_wdata  input  XLEN each  PC of instruction and of its successor.
REQ-012 err_valid  output  1  one-cycle pulse: last packet failed at least one check.
REQ-013 err_flags  output  6  sticky error bits {HALT,X0,RS2,RS1,PC,ORDER} = [5:0] MSB..LSB.
REQ-014 retired  output  64  count of accepted packets.
REQ-015 halted  output  1  monitor in HALTED state.

Function
REQ-016 FSM states SHALL be IDLE, RUN, HALTED; reset to IDLE.
REQ-017 IDLE: on rvfi_valid, SHALL latch expected order = rvfi_order+1 and expected PC = rvfi_pc_wdata, run rs/x0 checks only, go RUN (or HALTED if rvfi_halt).
REQ-018 RUN: each rvfi_valid packet SHALL be checked and retired incremented by 1 (wraps at 2^64); rvfi_halt with valid -> HALTED.
REQ-019 HALTED: any rvfi_valid SHALL set HALT flag and pulse err_valid; no other checks, no counter change; leave only by reset.
REQ-020 ORDER check (RUN): rvfi_order != expected order sets ORDER; expected order SHALL become rvfi_order+1 regardless, so one gap gives one error.
REQ-021 PC check (RUN): rvfi_pc_rdata != expected PC sets PC, except when rvfi_intr=1; expected PC SHALL always update to rvfi_pc_wdata.
REQ-022 X0 check: rvfi_rd_addr==0 with rvfi_rd_wdata!=0 sets X0.
REQ-023 Shadow register file: 32 x XLEN data plus 32 known bits; x0 permanently known with value 0.
REQ-024 RS1/RS2 check: if addressed register known and rdata differs, set RS1/RS2; if unknown, SHALL learn rdata and mark known (no error).
REQ-025 Shadow update: non-trapping packet with rd_addr!=0 SHALL write rd_wdata and mark known; trapping packet SHALL not write.
REQ-026 Same-packet rd==rs: rs checks SHALL use pre-update shadow value; learn and write to the same index in one packet: write wins.
REQ-027 Back-to-back packets: update from packet N SHALL be visible to packet N+1 on the next cycle (no bypass hazard).
REQ-028 Latency: err_valid and new err_flags bits SHALL appear the cycle after the offending rvfi_valid; retired likewise.
REQ-029 err_flags bits SHALL stay set until reset; rvfi_valid=0 cycles SHALL change no state.

Reset
REQ-030 On g_resetn low, asynchronously: FSM=IDLE, err_valid=0, err_flags=0, retired=0, halted=0, all known bits except x0 cleared, expected order/PC = 0.
REQ-031 Shadow data array need not be reset; known bits gate all use.
REQ-032 Reset asserted mid-stream SHALL discard all history; next packet treated per REQ-017.

Structure
REQ-033 Error bit indices and the FSM state enum SHALL live in the shared core package.
REQ-034 Shadow file SHALL be one sub-module core_rvfi_shadow_rf (2 async read ports, 1 write port, known-bit vector).

Verification
REQ-035 Orders 5,6,7 with continuous PCs 0x1000/0x1004/0x1008 -> no err_valid, retired=2 after third.
REQ-036 Orders 5,6,8 -> err_valid pulse after third, err_flags=0x01; order 9 next -> no new pulse.
REQ-037 Packet writes x3=0xAB; next reads rs1=x3 data 0xAC -> RS1 flag (0x04); rvfi_trap packet writing x3 does not alter shadow.
REQ-038 rd_addr=0, rd_wdata=0x1 -> X0 flag (0x10); pc_rdata mismatch with rvfi_intr=1 -> no PC flag.
REQ-039 Packet with rvfi_halt=1, then valid packet -> halted=1, HALT flag (0x20), retired unchanged.
REQ-040 Reset pulsed mid-stream after errors -> all outputs 0 same cycle; next packet with arbitrary order gives no ORDER error.
